uart_rx: RTL

//   UART receive-only block, the receive end of the link that uart_tx drives.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx_sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encoding, data width and
// the default oversampling ratio.
package uart_rx_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Parallel byte-side port of the UART receiver. The receiver drives the
// master modport, the byte consumer uses the slave modport. valid,
// frame_err and parity_err are single-cycle strobes with no back-pressure:
// the consumer must take data_out in the cycle valid is high. state is a
// read-only view of the receiver FSM. parity_err exists only when
// UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [UART_DATA_W-1:0] data_out;
    logic                   valid;
    logic                   frame_err;
    logic                   busy;
`ifdef UART_RX_PARITY_EN
    logic                   parity_err;
`endif
    state_t                 state;

`ifdef UART_RX_PARITY_EN
    modport master (output data_out, valid, frame_err, busy, parity_err, state);
    modport slave  (input  data_out, valid, frame_err, busy, parity_err, state);
`else
    modport master (output data_out, valid, frame_err, busy, state);
    modport slave  (input  data_out, valid, frame_err, busy, state);
`endif

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. RST_VAL sets the
// value both flops take in reset so the output matches the line's idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops resolve metastability before q is used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, one stop bit. The line is
// oversampled at CLKS_PER_BIT clocks per bit, the start bit is confirmed at
// its middle and every later bit is sampled one bit time after that.
// Optional feature: define UART_RX_PARITY_EN for 8E1 (even parity bit
// between data and stop, parity_err strobe on mismatch).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int            TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_MID = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(CLKS_PER_BIT - 1);

    logic                   rx_s;
    state_t                 state, state_nx;
    logic [TW-1:0]          tick, tick_nx;
    logic [2:0]             bitcnt, bitcnt_nx;
    logic [UART_DATA_W-1:0] shreg, shreg_nx;
    logic [UART_DATA_W-1:0] data_q, data_nx;
    logic                   valid_q, valid_nx;
    logic                   ferr_q, ferr_nx;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit, par_nx;
    logic                   perr_q, perr_nx;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, shift register and registered output strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            tick    <= tick_nx;
            bitcnt  <= bitcnt_nx;
            shreg   <= shreg_nx;
            data_q  <= data_nx;
            valid_q <= valid_nx;
            ferr_q  <= ferr_nx;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_nx;
            perr_q  <= perr_nx;
`endif
        end
    end

    // Next-state logic: tick counts clocks inside a bit, sampling happens
    // when it reaches the bit middle (start) or one full bit later (others)
    always_comb begin
        state_nx  = state;
        tick_nx   = tick + TW'(1);
        bitcnt_nx = bitcnt;
        shreg_nx  = shreg;
        data_nx   = data_q;
        valid_nx  = 1'b0;
        ferr_nx   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nx    = par_bit;
        perr_nx   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                tick_nx = '0;
                if (!rx_s) state_nx = ST_START;
            end
            ST_START: begin
                if (tick == TICK_MID) begin
                    tick_nx   = '0;
                    bitcnt_nx = '0;
                    // A high line at mid start bit was only a glitch
                    state_nx  = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick == TICK_END) begin
                    tick_nx          = '0;
                    shreg_nx[bitcnt] = rx_s;
                    bitcnt_nx        = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = ST_PARITY;
`else
                        state_nx = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick == TICK_END) begin
                    tick_nx  = '0;
                    par_nx   = rx_s;
                    state_nx = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick == TICK_END) begin
                    tick_nx  = '0;
                    // Back to IDLE right at mid stop bit so a following
                    // start edge with no idle gap is caught in time
                    state_nx = ST_IDLE;
                    if (!rx_s) begin
                        ferr_nx = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bit != ^shreg) begin
                        perr_nx = 1'b1;
`endif
                    end else begin
                        valid_nx = 1'b1;
                        data_nx  = shreg;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.state     = state;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule
